writeback_stage: RTL and testbench
==================================

# writeback_stage

MEM/WB pipeline register and write-back datapath of the RV32I core. It captures the memory-stage result each cycle and extracts and sign- or zero-extends load data. It selects the value to commit and drives the write port (`reg_write`, `rd`, `write_data`) of the register file directly. It also keeps a retired-instruction counter.

## Interface
Parameters:
- `RETIRE_W`, default 32: width of the retired-instruction counter.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `stall`  in  1  hold the WB register contents.
- `flush`  in  1  load a bubble into the WB register.
- `mem_valid`  in  1  MEM stage holds a real instruction.
- `mem_reg_write`  in  1  the instruction writes `rd`.
- `mem_rd`  in  5  destination register index.
- `mem_wb_sel`  in  2  result select: 00 ALU, 01 load, 10 PC+4, 11 treated as ALU.
- `mem_funct3`  in  3  load width/sign code.
- `mem_alu_result`  in  32  ALU result, also the load byte address.
- `mem_load_data`  in  32  raw word-aligned data-memory read word.
- `mem_pc_plus4`  in  32  return address for JAL/JALR.
- `wb_valid`  out  1  WB register holds a real instruction.
- `wb_reg_write`  out  1  to register file `reg_write`.
- `wb_rd`  out  5  to register file `rd`.
- `wb_write_data`  out  32  to register file `write_data`.
- `retire_count`  out  `RETIRE_W`  count of retired instructions.

## Operation
- State: WB register fields are valid, reg_write, rd, wb_sel, funct3, alu_result, load_data, pc_plus4; plus `retire_count`.
- Priority at each rising edge is `flush` > `stall` > capture.
  - `flush`=1: valid←0, reg_write←0. Other fields are don't-care, but the implementation zeroes them.
  - `stall`=1, `flush`=0: all fields hold.
  - Otherwise: every field ← the corresponding `mem_*` input.
- `wb_valid` = stored valid.
- `wb_reg_write` = valid & reg_write & (rd ≠ 0). The x0 write is suppressed here as well as in the register file.
- `wb_rd` = stored rd.
- `wb_write_data` is combinational from stored fields:
  - wb_sel 00/11 → alu_result.
  - wb_sel 10 → pc_plus4.
  - wb_sel 01 → extracted load value.
- Load extraction, with offset = alu_result[1:0]:
  - funct3 000 LB: byte[offset], sign-extended.
  - funct3 100 LBU: byte[offset], zero-extended.
  - funct3 001 LH: halfword at offset[1] (bits 31:16 if offset[1]=1, else 15:0), sign-extended.
  - funct3 101 LHU: same halfword, zero-extended.
  - funct3 010, 011, 110, 111: full word.
  - offset[0] is ignored for halfwords. Misalignment is not detected here.
- Byte numbering is little-endian: byte0 = bits 7:0, byte3 = bits 31:24.
- `retire_count` increments by 1 at each rising edge where valid=1 and `stall`=0. The count is taken regardless of `flush` and of reg_write, so stores, branches and rd=0 instructions all count.
- `retire_count` wraps modulo 2^`RETIRE_W`, from all-ones to 0.
- A stalled instruction re-asserts the same register-file write each cycle. This is harmless and is counted once.

## Timing
- Latency: `mem_*` sampled at edge N → `wb_*` valid after edge N → register file updated at edge N+1.
- `wb_write_data` and `wb_reg_write` are combinational from the WB register. They have no dependence on current-cycle inputs except through the register.
- Reset values (async, immediate on `rst` rising, no clock needed): `wb_valid`=0, `wb_reg_write`=0, `wb_rd`=0, `wb_write_data`=0x00000000, `retire_count`=0. All stored fields are zero.
- Reset mid-operation discards the held instruction. No register-file write occurs while `rst`=1.
- After `rst` deasserts, the first capture happens at the next rising edge.
- `stall` and `flush` asserted together → bubble. Counter increments if the outgoing instruction was valid.

## Test plan
- Reset: with wb_valid=1 and retire_count=5, pulse `rst` between edges → all outputs read 0 before the next edge, and stay 0 until the first capture.
- Loads with load_data=0x80FF1234, wb_sel=01:
  - LB, addr …3 → 0xFFFFFF80.
  - LBU, addr …3 → 0x00000080.
  - LH, addr …2 → 0xFFFF80FF.
  - LHU, addr …2 → 0x000080FF.
  - LB, addr …0 → 0x00000034.
  - LW → 0x80FF1234.
  - Each value appears one cycle after capture.
- Select paths:
  - wb_sel=10, pc_plus4=0x00000104 → write_data 0x00000104.
  - wb_sel=11, alu=0xDEADBEEF → 0xDEADBEEF.
- x0 suppression: mem_reg_write=1, rd=0, valid=1 → wb_reg_write=0; retire_count still +1.
- Stall/flush:
  - 3-cycle `stall` → outputs frozen, count +0 during the stall, +1 when released.
  - `stall`+`flush` together → wb_valid=0 next cycle.
  - `flush` with mem_valid=1 → no write and no count for that instruction.
- Counter wrap with RETIRE_W=4: 17 consecutive valid unstalled instructions → count reads 15 then 0 then 1.

Source files
------------

// File: rtl/writeback_stage.sv
// MEM/WB pipeline register and write-back datapath for the RV32I core.
// Selects the commit value, extracts load data, and counts retired instructions.
module writeback_stage #(
  parameter int unsigned RETIRE_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                flush,
  input  logic                mem_valid,
  input  logic                mem_reg_write,
  input  logic [4:0]          mem_rd,
  input  logic [1:0]          mem_wb_sel,
  input  logic [2:0]          mem_funct3,
  input  logic [31:0]         mem_alu_result,
  input  logic [31:0]         mem_load_data,
  input  logic [31:0]         mem_pc_plus4,
  output logic                wb_valid,
  output logic                wb_reg_write,
  output logic [4:0]          wb_rd,
  output logic [31:0]         wb_write_data,
  output logic [RETIRE_W-1:0] retire_count
);

  localparam int unsigned XLEN = 32;

  typedef struct packed {
    logic            valid;
    logic            reg_write;
    logic [4:0]      rd;
    logic [1:0]      wb_sel;
    logic [2:0]      funct3;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] load_data;
    logic [XLEN-1:0] pc_plus4;
  } wb_reg_t;

  wb_reg_t             wb_q;
  logic [RETIRE_W-1:0] retire_q;
  logic [7:0]          ld_byte;
  logic [15:0]         ld_half;
  logic [XLEN-1:0]     ld_value;

  // Pipeline register: flush beats stall beats capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_q <= '0;
    end else if (flush) begin
      wb_q <= '0;
    end else if (!stall) begin
      wb_q <= '{valid:      mem_valid,
                reg_write:  mem_reg_write,
                rd:         mem_rd,
                wb_sel:     mem_wb_sel,
                funct3:     mem_funct3,
                alu_result: mem_alu_result,
                load_data:  mem_load_data,
                pc_plus4:   mem_pc_plus4};
    end
  end

  // An instruction retires when it leaves WB, either advancing or being flushed out
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retire_q <= '0;
    end else if (wb_q.valid && (flush || !stall)) begin
      retire_q <= retire_q + RETIRE_W'(1);
    end
  end

  // Little-endian byte/halfword extraction; offset[0] ignored for halfwords
  always_comb begin
    ld_byte  = 8'h00;
    ld_half  = 16'h0000;
    ld_value = wb_q.load_data;
    case (wb_q.alu_result[1:0])
      2'd0:    ld_byte = wb_q.load_data[7:0];
      2'd1:    ld_byte = wb_q.load_data[15:8];
      2'd2:    ld_byte = wb_q.load_data[23:16];
      default: ld_byte = wb_q.load_data[31:24];
    endcase
    ld_half = wb_q.alu_result[1] ? wb_q.load_data[31:16] : wb_q.load_data[15:0];
    case (wb_q.funct3)
      3'b000:  ld_value = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_value = {24'h000000, ld_byte};
      3'b001:  ld_value = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_value = {16'h0000, ld_half};
      default: ld_value = wb_q.load_data;
    endcase
  end

  always_comb begin
    wb_write_data = wb_q.alu_result;
    case (wb_q.wb_sel)
      2'b01:   wb_write_data = ld_value;
      2'b10:   wb_write_data = wb_q.pc_plus4;
      default: wb_write_data = wb_q.alu_result;
    endcase
  end

  assign wb_valid     = wb_q.valid;
  assign wb_reg_write = wb_q.valid & wb_q.reg_write & (wb_q.rd != 5'd0);
  assign wb_rd        = wb_q.rd;
  assign retire_count = retire_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: directed cases plus random traffic
// against a behavioural model; a second instance with a 4-bit counter covers wrap.
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, flush;
  logic        mem_valid, mem_reg_write;
  logic [4:0]  mem_rd;
  logic [1:0]  mem_wb_sel;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_alu_result, mem_load_data, mem_pc_plus4;

  logic        wb_valid, wb_reg_write;
  logic [4:0]  wb_rd;
  logic [31:0] wb_write_data;
  logic [31:0] retire_count;

  logic        w4_valid, w4_reg_write;
  logic [4:0]  w4_rd;
  logic [31:0] w4_write_data;
  logic [3:0]  retire_count4;

  int total = 0;
  int bad   = 0;

  // Reference model state: the instruction currently sitting in WB
  logic        m_valid, m_rw;
  logic [4:0]  m_rd;
  logic [1:0]  m_sel;
  logic [2:0]  m_f3;
  logic [31:0] m_alu, m_ld, m_pc;
  logic [31:0] m_cnt;

  always #5 clk = ~clk;

  writeback_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .mem_valid(mem_valid), .mem_reg_write(mem_reg_write), .mem_rd(mem_rd),
    .mem_wb_sel(mem_wb_sel), .mem_funct3(mem_funct3),
    .mem_alu_result(mem_alu_result), .mem_load_data(mem_load_data),
    .mem_pc_plus4(mem_pc_plus4),
    .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
    .wb_write_data(wb_write_data), .retire_count(retire_count)
  );

  writeback_stage #(.RETIRE_W(4)) dut4 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .mem_valid(mem_valid), .mem_reg_write(mem_reg_write), .mem_rd(mem_rd),
    .mem_wb_sel(mem_wb_sel), .mem_funct3(mem_funct3),
    .mem_alu_result(mem_alu_result), .mem_load_data(mem_load_data),
    .mem_pc_plus4(mem_pc_plus4),
    .wb_valid(w4_valid), .wb_reg_write(w4_reg_write), .wb_rd(w4_rd),
    .wb_write_data(w4_write_data), .retire_count(retire_count4)
  );

  // Load value by shifting the addressed unit down to bit 0, then extending
  function automatic logic [31:0] load_val(input logic [2:0] f3, input logic [31:0] addr,
                                           input logic [31:0] data);
    logic [31:0] b, h;
    b = data >> (8 * int'(addr[1:0]));
    h = data >> (16 * int'(addr[1]));
    case (f3)
      3'b000:  return ((b & 32'hFF) ^ 32'h80) - 32'h80;
      3'b100:  return b & 32'hFF;
      3'b001:  return ((h & 32'hFFFF) ^ 32'h8000) - 32'h8000;
      3'b101:  return h & 32'hFFFF;
      default: return data;
    endcase
  endfunction

  function automatic logic [31:0] exp_wd();
    if (m_sel == 2'b10) return m_pc;
    if (m_sel == 2'b01) return load_val(m_f3, m_alu, m_ld);
    return m_alu;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("wb_valid", 32'(wb_valid), 32'(m_valid));
    chk("wb_reg_write", 32'(wb_reg_write), 32'(m_valid && m_rw && (m_rd != 5'd0)));
    chk("wb_rd", 32'(wb_rd), 32'(m_rd));
    chk("wb_write_data", wb_write_data, exp_wd());
    chk("retire_count", retire_count, m_cnt);
    chk("retire_count4", 32'(retire_count4), m_cnt & 32'hF);
  endtask

  task automatic model_reset();
    m_valid = 1'b0; m_rw = 1'b0; m_rd = '0; m_sel = '0; m_f3 = '0;
    m_alu = '0; m_ld = '0; m_pc = '0; m_cnt = '0;
  endtask

  // Advance one clock: update model from current inputs, then check after the edge
  task automatic step();
    if (m_valid && (flush || !stall)) m_cnt = m_cnt + 32'd1;
    if (flush) begin
      m_valid = 1'b0; m_rw = 1'b0; m_rd = '0; m_sel = '0; m_f3 = '0;
      m_alu = '0; m_ld = '0; m_pc = '0;
    end else if (!stall) begin
      m_valid = mem_valid; m_rw = mem_reg_write; m_rd = mem_rd; m_sel = mem_wb_sel;
      m_f3 = mem_funct3; m_alu = mem_alu_result; m_ld = mem_load_data; m_pc = mem_pc_plus4;
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic drive(input logic v, input logic rw, input logic [4:0] rd,
                       input logic [1:0] sel, input logic [2:0] f3, input logic [31:0] alu,
                       input logic [31:0] ld, input logic [31:0] pc);
    mem_valid = v; mem_reg_write = rw; mem_rd = rd; mem_wb_sel = sel;
    mem_funct3 = f3; mem_alu_result = alu; mem_load_data = ld; mem_pc_plus4 = pc;
  endtask

  task automatic load_case(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] exp);
    drive(1'b1, 1'b1, 5'd7, 2'b01, f3, addr, 32'h80FF1234, 32'h0);
    step();
    chk(tag, wb_write_data, exp);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    drive(1'b0, 1'b0, 5'd0, 2'b00, 3'b000, 32'h0, 32'h0, 32'h0);
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_all();

    // Build up valid=1, count=5, then reset between edges
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b1, 5'(i + 1), 2'b00, 3'b010, 32'h100 + 32'(i), 32'h0, 32'h0);
      step();
    end
    chk("pre_reset_count", retire_count, 32'd5);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all();
    rst = 1'b0;
    #1;
    check_all();

    // Counter wrap: 4-bit instance reads 15, 0, 1
    for (int i = 1; i <= 18; i++) begin
      drive(1'b1, i[0], 5'(i), 2'b00, 3'b010, 32'(i), 32'h0, 32'h0);
      step();
      if (i == 16) chk("wrap_15", 32'(retire_count4), 32'd15);
      if (i == 17) chk("wrap_0", 32'(retire_count4), 32'd0);
      if (i == 18) chk("wrap_1", 32'(retire_count4), 32'd1);
    end

    load_case("lb_off3",  3'b000, 32'h1003, 32'hFFFFFF80);
    load_case("lbu_off3", 3'b100, 32'h1003, 32'h00000080);
    load_case("lh_off2",  3'b001, 32'h1002, 32'hFFFF80FF);
    load_case("lhu_off2", 3'b101, 32'h1002, 32'h000080FF);
    load_case("lb_off0",  3'b000, 32'h1000, 32'h00000034);
    load_case("lw",       3'b010, 32'h1000, 32'h80FF1234);

    drive(1'b1, 1'b1, 5'd1, 2'b10, 3'b000, 32'h55, 32'h0, 32'h00000104);
    step();
    chk("sel_pc4", wb_write_data, 32'h00000104);
    drive(1'b1, 1'b1, 5'd2, 2'b11, 3'b000, 32'hDEADBEEF, 32'h0, 32'h4);
    step();
    chk("sel_11", wb_write_data, 32'hDEADBEEF);

    // x0 destination: no write, still retires
    drive(1'b1, 1'b1, 5'd0, 2'b00, 3'b000, 32'h1234, 32'h0, 32'h0);
    step();
    chk("x0_we", 32'(wb_reg_write), 32'd0);
    drive(1'b0, 1'b0, 5'd3, 2'b00, 3'b000, 32'h0, 32'h0, 32'h0);
    step();

    // Three-cycle stall on a valid instruction
    drive(1'b1, 1'b1, 5'd9, 2'b00, 3'b000, 32'hCAFE0001, 32'h0, 32'h0);
    step();
    drive(1'b1, 1'b1, 5'd10, 2'b00, 3'b000, 32'hCAFE0002, 32'h0, 32'h0);
    stall = 1'b1;
    repeat (3) step();
    chk("stall_hold_data", wb_write_data, 32'hCAFE0001);
    stall = 1'b0;
    step();

    // Stall and flush together: bubble, outgoing valid still counts
    stall = 1'b1; flush = 1'b1;
    step();
    chk("stall_flush_valid", 32'(wb_valid), 32'd0);
    stall = 1'b0; flush = 1'b0;

    // Flush while MEM holds a valid instruction
    drive(1'b1, 1'b1, 5'd11, 2'b00, 3'b000, 32'h77, 32'h0, 32'h0);
    flush = 1'b1;
    step();
    chk("flush_we", 32'(wb_reg_write), 32'd0);
    flush = 1'b0;
    drive(1'b0, 1'b0, 5'd0, 2'b00, 3'b000, 32'h0, 32'h0, 32'h0);
    step();

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom), 1'($urandom), 5'($urandom), 2'($urandom), 3'($urandom),
            32'($urandom), 32'($urandom), 32'($urandom));
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 7) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
